// File: rtl/riscv_mdu_pkg.sv
// Shared types and op-decode helpers
// for the multiply/divide unit.
package riscv_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_signed_a(op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/riscv_mdu_if.sv
// Request/response bundle between the
// execute stage and the MDU.
interface riscv_mdu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            Zero;
    logic            Negative;
    logic            DivZero;
    logic            Overflow;

    modport master (
        output in_valid, op, A, B, flush, out_ready,
        input  in_ready, out_valid, result,
        input  Zero, Negative, DivZero, Overflow
    );

    modport slave (
        input  in_valid, op, A, B, flush, out_ready,
        output in_ready, out_valid, result,
        output Zero, Negative, DivZero, Overflow
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration: shift-add multiply
// or restoring shift-subtract divide.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            div,
    input  logic [XLEN:0]   acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN:0]   acc_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    // single shift-add / shift-subtract step
    always_comb begin
        sum  = acc_i + (lo_i[0] ? {1'b0, opd_i} : '0);
        shl  = {acc_i[XLEN-1:0], lo_i[XLEN-1]};
        diff = shl - {1'b0, opd_i};
        if (div) begin
            acc_o = diff[XLEN] ? shl : diff;
            lo_o  = {lo_i[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_o = {1'b0, sum[XLEN:1]};
            lo_o  = {sum[0], lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit:
// FSM, sign handling, result registers.
module riscv_mdu
    import riscv_mdu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input logic         clk,
    input logic         rst_n,
    riscv_mdu_if.slave  m
);
    state_e            state_q, state_d;
    op_e               op_q;
    logic              neg_q;
    logic [XLEN:0]     acc_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   opd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   res_q;
    logic              z_q, n_q, dz_q, ov_q;

    op_e               op_in;
    logic              accept;
    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              b_zero, ovf, fast;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN:0]     acc_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, sel;
    logic              last;
    logic              done;

    assign op_in  = op_e'(m.op);
    assign accept = (state_q == S_IDLE) && m.in_valid && !m.flush;
    assign last   = (cnt_q == CNT_W'(1));

    // operand magnitudes and fast-path decode
    always_comb begin
        sa     = is_signed_a(op_in) & m.A[XLEN-1];
        sb     = is_signed_b(op_in) & m.B[XLEN-1];
        mag_a  = sa ? -m.A : m.A;
        mag_b  = sb ? -m.B : m.B;
        b_zero = (m.B == '0);
        ovf    = (op_in inside {OP_DIV, OP_REM})
               && (m.A == {1'b1, {(XLEN-1){1'b0}}})
               && (&m.B);
        fast   = is_div(op_in) && (b_zero || ovf);
        if (b_zero)
            fast_res = is_rem(op_in) ? m.A : '1;
        else
            fast_res = is_rem(op_in) ? '0 : m.A;
    end

    mdu_step #(.XLEN(XLEN)) u_step (
        .div   (is_div(op_q)),
        .acc_i (acc_q),
        .lo_i  (lo_q),
        .opd_i (opd_q),
        .acc_o (acc_n),
        .lo_o  (lo_n)
    );

    // sign-corrected result selection
    always_comb begin
        prod   = {acc_n[XLEN-1:0], lo_n};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_n : lo_n;
        rem_s  = neg_q ? -acc_n[XLEN-1:0]
                       : acc_n[XLEN-1:0];
        unique case (op_q)
            OP_MUL:                       sel = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sel = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              sel = quo_s;
            default:                      sel = rem_s;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (m.flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (m.in_valid)
                            state_d = fast ? S_DONE : S_CALC;
                S_CALC: if (last) state_d = S_DONE;
                S_DONE: if (m.out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // datapath, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MUL;
            neg_q <= 1'b0;
            acc_q <= '0;
            lo_q  <= '0;
            opd_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            dz_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (accept) begin
            op_q  <= op_in;
            neg_q <= is_rem(op_in) ? sa : (sa ^ sb);
            acc_q <= '0;
            lo_q  <= is_div(op_in) ? mag_a : mag_b;
            opd_q <= is_div(op_in) ? mag_b : mag_a;
            cnt_q <= CNT_W'(XLEN);
            if (fast) begin
                res_q <= fast_res;
                z_q   <= (fast_res == '0);
                n_q   <= fast_res[XLEN-1];
                dz_q  <= b_zero;
                ov_q  <= ovf && !b_zero;
            end
        end else if (state_q == S_CALC && !m.flush) begin
            acc_q <= acc_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last) begin
                res_q <= sel;
                z_q   <= (sel == '0);
                n_q   <= sel[XLEN-1];
                dz_q  <= 1'b0;
                ov_q  <= 1'b0;
            end
        end
    end

    assign done        = (state_q == S_DONE);
    assign m.in_ready  = (state_q == S_IDLE);
    assign m.out_valid = done;
    assign m.result    = done ? res_q : '0;
    assign m.Zero      = done & z_q;
    assign m.Negative  = done & n_q;
    assign m.DivZero   = done & dz_q;
    assign m.Overflow  = done & ov_q;

endmodule
